sim_monitor: RTL

SIM_MONITOR -- requirements
Module: sim_monitor

---
 rtl/sim_pkg.sv | 21 ++
 rtl/sim_sat_cnt.sv | 21 ++
 rtl/sim_monitor.sv | 101 ++++++++++
 3 files changed

// File: rtl/sim_pkg.sv
// Shared types for the simulation monitor: FSM states, end-cause codes
// and the width of the CPU reset-hold counter.
package sim_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        HALTED   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_TRAP    = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_HANG    = 2'd3
    } status_t;

    // RST_CYCLES is at most 255
    localparam int HOLD_W = 8;

endpackage

// File: rtl/sim_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sim_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/sim_monitor.sv
// Testbench-side CPU monitor: holds the core in reset, counts cycles and
// retires, and latches the end cause (trap, timeout or hang).
module sim_monitor
    import sim_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int CNT_W          = 64,
    parameter int RST_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int STALL_LIMIT    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    output logic             cpu_rst,
    input  logic             retire,
    input  logic             halt,
    input  logic [XLEN-1:0]  halt_code,
    output logic             done,
    output logic             pass,
    output logic [1:0]       status,
    output logic [XLEN-1:0]  exit_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int SW = $clog2(STALL_LIMIT) + 1;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SW-1:0]     stall_cnt;
    logic              run;
    logic              timeout_hit;
    logic              hang_hit;

    assign run         = (state == RUN);
    assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign hang_hit    = !retire && (stall_cnt == SW'(STALL_LIMIT - 1));

    // Counters advance in every RUN cycle, including the one that ends the run
    sim_sat_cnt #(.W(CNT_W)) u_cycle (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(run), .q(cycle_cnt)
    );

    sim_sat_cnt #(.W(CNT_W)) u_instret (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(run && retire), .q(instret_cnt)
    );

    sim_sat_cnt #(.W(SW)) u_stall (
        .clk(clk), .rst(rst), .clr(run && retire), .inc(run && !retire), .q(stall_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_HOLD;
            cpu_rst   <= 1'b1;
            hold_cnt  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            status    <= ST_NONE;
            exit_code <= '0;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // Priority: trap, then timeout, then hang
                    if (halt) begin
                        state     <= HALTED;
                        cpu_rst   <= 1'b1;
                        done      <= 1'b1;
                        status    <= ST_TRAP;
                        exit_code <= halt_code;
                        pass      <= (halt_code == '0);
                    end else if (timeout_hit) begin
                        state   <= HALTED;
                        cpu_rst <= 1'b1;
                        done    <= 1'b1;
                        status  <= ST_TIMEOUT;
                    end else if (hang_hit) begin
                        state   <= HALTED;
                        cpu_rst <= 1'b1;
                        done    <= 1'b1;
                        status  <= ST_HANG;
                    end
                end
                HALTED: ;
                default: begin
                    state   <= RST_HOLD;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule
